scale_frame_sequencer: RTL and testbench
========================================

Name: scale_frame_sequencer

Overview:
- Control front-end for the 2PPC 2x nearest-neighbour scale-down datapath.
- Tracks raw 2PPC stream geometry from start-of-frame/end-of-line markers and generates the beat X and line Y coordinates the scaler consumes.
- Latches scaler configuration only at frame boundaries and applies frame decimation.
- Checks line/frame length and reports sticky errors. Sits between camera capture and the scaler.

Parameters:
- P_DEPTH, 8, bits per colour component per pixel
- IN_FRAME_WIDTH, 1080, pixels per line; multiple of 4; beats per line = IN_FRAME_WIDTH/2
- IN_FRAME_HEIGHT, 720, lines per frame
- FCNT_W, 16, width of completed-frame counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cfg_scale_en  in  1  requested scale enable (1 = scale, 0 = bypass)
- cfg_skip  in  4  frames dropped after each emitted frame (0 = none)
- err_clr  in  1  single-cycle clear of sticky error flags
- in_valid  in  1  input beat valid
- in_sof  in  1  first beat of frame, qualified by in_valid
- in_eol  in  1  last beat of line, qualified by in_valid
- in_data  in  6*P_DEPTH  {R,G,B} 2PPC beat
- out_valid  out  1  beat valid towards scaler
- out_x  out  11  beat index within line
- out_y  out  11  line index within frame
- out_data  out  6*P_DEPTH  registered in_data
- scale_en  out  1  frame-latched scale enable
- frame_done  out  1  one-cycle pulse after last beat of an emitted frame
- frame_cnt  out  FCNT_W  completed emitted frames, wraps
- err_line_len  out  1  sticky: line length mismatch
- err_frame_len  out  1  sticky: SOF before frame complete

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, x/y/skip counters 0. Reset mid-frame abandons the frame; no frame_done.
- All outputs registered; out_* carry the beat from 1 cycle earlier. Cycles with in_valid=0 never advance counters; out_valid=0 there.
- States: IDLE, ACTIVE, SKIP.
- IDLE: ignore beats until in_valid&in_sof. On that beat, latch scale_en<=cfg_scale_en. If skip_cnt==0, go to ACTIVE and reload skip_cnt<=cfg_skip; else go to SKIP and decrement skip_cnt. The SOF beat is beat x=0, y=0.
- ACTIVE: out_valid<=in_valid, out_x<=x, out_y<=y, out_data<=in_data.
- SKIP: identical counting, but out_valid held 0.
- Line end occurs on the earlier of in_eol or x==IN_FRAME_WIDTH/2-1. At line end, x<=0 and y<=y+1; otherwise x<=x+1.
- err_line_len is set if in_eol arrives with x!=W/2-1, or if x==W/2-1 arrives without in_eol.
- Frame end is the line end with y==IN_FRAME_HEIGHT-1. Then go to IDLE. In ACTIVE, also pulse frame_done for one cycle (aligned with out_valid of the last beat) and increment frame_cnt (wraps to 0 at all-ones).
- in_sof in ACTIVE/SKIP: set err_frame_len and restart as a new frame from that beat. The abandoned frame gets no frame_done. The new frame is decided as in IDLE.
- in_sof with in_eol on the same beat: SOF takes priority; x becomes 1 on the next beat, no line-length error.
- err_clr and a new error event in the same cycle: the flag stays set.
- cfg_* changes mid-frame have no effect until the next SOF.

Decomposition:
- Shared package: state encoding (IDLE/ACTIVE/SKIP) and the coordinate width constant (11).
- One natural sub-module, frame_geom_counter: the x/y counters, line/frame-end detection and the line-length check. The top holds the FSM, skip counter, config latch and output registers.

Test Plan (IN_FRAME_WIDTH=8, IN_FRAME_HEIGHT=4, 4 beats/line):
- Assert rst mid-frame at y=2 -> all outputs 0 immediately. Next SOF starts at out_x=0, out_y=0. No frame_done.
- cfg_skip=0; SOF + 16 beats with in_eol on every 4th -> out_x 0,1,2,3 repeating, out_y 0..3. frame_done is high exactly with the 16th out_valid. frame_cnt=1. No errors.
- cfg_skip=1; 3 back-to-back frames -> frames 1 and 3 emit 16 out_valid each. Frame 2 emits none. frame_cnt=2.
- in_eol at x=2 on line 0 -> err_line_len=1. Next beat out_x=0, out_y=1. err_clr -> flag 0 the following cycle.
- in_sof at y=2, x=1 -> err_frame_len=1. That beat emits out_x=0, out_y=0. No frame_done for the aborted frame.
- cfg_scale_en toggled 0->1 mid-frame, with in_valid gaps of 3 cycles -> scale_en stays 0 until the next SOF. Counters frozen during gaps.

Source files
------------

// File: rtl/scale_frame_sequencer_pkg.sv
// Shared definitions for the scale-down front-end: FSM encoding and coordinate width.
package scale_frame_sequencer_pkg;

    localparam int COORD_W = 11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_SKIP   = 2'd2;

endpackage

// File: rtl/scale_frame_sequencer_geom.sv
// frame_geom_counter: beat/line coordinates of the current beat plus line/frame-end detection
// and the line-length check; outputs describe the beat presented this cycle.
module frame_geom_counter
    import scale_frame_sequencer_pkg::*;
#(
    parameter int IN_FRAME_WIDTH  = 1080,
    parameter int IN_FRAME_HEIGHT = 720
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               beat_vld,
    input  logic               beat_sof,
    input  logic               beat_eol,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_end,
    output logic               frame_end,
    output logic               len_err
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IN_FRAME_WIDTH / 2 - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IN_FRAME_HEIGHT - 1);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               at_last;

    // An SOF beat is always coordinate (0,0) and never ends a line, even with eol set.
    always_comb begin
        at_last   = (x_q == X_LAST);
        x         = beat_sof ? '0 : x_q;
        y         = beat_sof ? '0 : y_q;
        line_end  = !beat_sof && (beat_eol || at_last);
        frame_end = line_end && (y_q == Y_LAST);
        len_err   = !beat_sof && (beat_eol != at_last);
        x_d       = x_q;
        y_d       = y_q;
        if (beat_vld) begin
            if (beat_sof) begin
                x_d = COORD_W'(1);
                y_d = '0;
            end else if (line_end) begin
                x_d = '0;
                y_d = frame_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/scale_frame_sequencer.sv
// Front-end sequencer for the 2PPC 2x scale-down: frame FSM, decimation, config latch,
// registered beat/coordinate outputs and sticky geometry error flags.
module scale_frame_sequencer
    import scale_frame_sequencer_pkg::*;
#(
    parameter int P_DEPTH         = 8,
    parameter int IN_FRAME_WIDTH  = 1080,
    parameter int IN_FRAME_HEIGHT = 720,
    parameter int FCNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_scale_en,
    input  logic [3:0]           cfg_skip,
    input  logic                 err_clr,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic                 in_eol,
    input  logic [6*P_DEPTH-1:0] in_data,
    output logic                 out_valid,
    output logic [COORD_W-1:0]   out_x,
    output logic [COORD_W-1:0]   out_y,
    output logic [6*P_DEPTH-1:0] out_data,
    output logic                 scale_en,
    output logic                 frame_done,
    output logic [FCNT_W-1:0]    frame_cnt,
    output logic                 err_line_len,
    output logic                 err_frame_len
);

    logic [1:0]           state_q, state_d;
    logic [3:0]           skip_q, skip_d;
    logic                 scale_en_q, scale_en_d;
    logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [COORD_W-1:0]   out_x_q, out_x_d;
    logic [COORD_W-1:0]   out_y_q, out_y_d;
    logic [6*P_DEPTH-1:0] out_data_q, out_data_d;
    logic                 frame_done_q, frame_done_d;
    logic                 err_line_q, err_line_d;
    logic                 err_frame_q, err_frame_d;

    logic                 sof_beat;
    logic                 beat_vld;
    logic [COORD_W-1:0]   geo_x, geo_y;
    logic                 geo_line_end, geo_frame_end, geo_len_err;
    logic                 emit, frame_ev;

    assign sof_beat = in_valid && in_sof;
    assign beat_vld = in_valid && ((state_q != ST_IDLE) || in_sof);

    frame_geom_counter #(
        .IN_FRAME_WIDTH  (IN_FRAME_WIDTH),
        .IN_FRAME_HEIGHT (IN_FRAME_HEIGHT)
    ) u_geom (
        .clk       (clk),
        .rst       (rst),
        .beat_vld  (beat_vld),
        .beat_sof  (sof_beat),
        .beat_eol  (in_eol),
        .x         (geo_x),
        .y         (geo_y),
        .line_end  (geo_line_end),
        .frame_end (geo_frame_end),
        .len_err   (geo_len_err)
    );

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        scale_en_d   = scale_en_q;
        frame_cnt_d  = frame_cnt_q;
        emit         = 1'b0;
        frame_ev     = 1'b0;
        frame_done_d = 1'b0;
        // SOF restarts from any state; mid-frame it abandons the running frame.
        if (sof_beat) begin
            frame_ev   = (state_q != ST_IDLE);
            scale_en_d = cfg_scale_en;
            if (skip_q == 4'd0) begin
                state_d = ST_ACTIVE;
                skip_d  = cfg_skip;
                emit    = 1'b1;
            end else begin
                state_d = ST_SKIP;
                skip_d  = skip_q - 4'd1;
            end
        end else if (in_valid && (state_q != ST_IDLE)) begin
            emit = (state_q == ST_ACTIVE);
            if (geo_frame_end) begin
                state_d = ST_IDLE;
                if (emit) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                end
            end
        end
        out_valid_d = emit;
        out_x_d     = geo_x;
        out_y_d     = geo_y;
        out_data_d  = in_data;
        err_line_d  = (err_line_q && !err_clr) || (beat_vld && geo_len_err);
        err_frame_d = (err_frame_q && !err_clr) || frame_ev;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            skip_q       <= '0;
            scale_en_q   <= 1'b0;
            frame_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            err_line_q   <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            scale_en_q   <= scale_en_d;
            frame_cnt_q  <= frame_cnt_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            err_line_q   <= err_line_d;
            err_frame_q  <= err_frame_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_x         = out_x_q;
    assign out_y         = out_y_q;
    assign out_data      = out_data_q;
    assign scale_en      = scale_en_q;
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_line_len  = err_line_q;
    assign err_frame_len = err_frame_q;

    logic unused_ok;
    assign unused_ok = geo_line_end;

endmodule

// File: tb/tb_scale_frame_sequencer.sv
// Directed bench for scale_frame_sequencer on an 8x4 frame (4 beats per line).
module tb_scale_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_scale_en;
    logic [3:0]  cfg_skip;
    logic        err_clr;
    logic        in_valid, in_sof, in_eol;
    logic [47:0] in_data;
    logic        out_valid;
    logic [10:0] out_x, out_y;
    logic [47:0] out_data;
    logic        scale_en, frame_done;
    logic [15:0] frame_cnt;
    logic        err_line_len, err_frame_len;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        done;
        logic [47:0] data;
    } exp_t;

    exp_t exp_q[$];

    scale_frame_sequencer #(
        .P_DEPTH(8), .IN_FRAME_WIDTH(8), .IN_FRAME_HEIGHT(4), .FCNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .cfg_scale_en(cfg_scale_en), .cfg_skip(cfg_skip),
        .err_clr(err_clr), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
        .in_data(in_data), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
        .out_data(out_data), .scale_en(scale_en), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .err_line_len(err_line_len), .err_frame_len(err_frame_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One input cycle; emitted beats are queued as expected, then popped once the DUT registers them.
    task automatic beat(input logic v, input logic s, input logic e,
                        input logic emit, input int ex, input int ey, input logic ed);
        exp_t t;
        logic [47:0] d;
        d = {16'($urandom), 32'($urandom)};
        in_valid = v; in_sof = s; in_eol = e; in_data = d;
        if (emit) begin
            t.x = 11'(ex); t.y = 11'(ey); t.done = ed; t.data = d;
            exp_q.push_back(t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        chk("out_valid", 64'(out_valid), 64'(emit));
        if (out_valid && exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("out_x", 64'(out_x), 64'(t.x));
            chk("out_y", 64'(out_y), 64'(t.y));
            chk("frame_done", 64'(frame_done), 64'(t.done));
            chk("out_data", 64'(out_data), 64'(t.data));
        end else begin
            exp_q.delete();
            chk("frame_done_quiet", 64'(frame_done), 64'(0));
        end
    endtask

    task automatic run_frame(input logic emit);
        for (int i = 0; i < 16; i++)
            beat(1'b1, i == 0, (i % 4) == 3, emit, i % 4, i / 4, emit && (i == 15));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_x"}, 64'(out_x), 64'(0));
        chk({tag, "_y"}, 64'(out_y), 64'(0));
        chk({tag, "_data"}, 64'(out_data), 64'(0));
        chk({tag, "_scale_en"}, 64'(scale_en), 64'(0));
        chk({tag, "_done"}, 64'(frame_done), 64'(0));
        chk({tag, "_cnt"}, 64'(frame_cnt), 64'(0));
        chk({tag, "_err_line"}, 64'(err_line_len), 64'(0));
        chk({tag, "_err_frame"}, 64'(err_frame_len), 64'(0));
    endtask

    initial begin
        rst = 1'b1; cfg_scale_en = 1'b1; cfg_skip = 4'd0; err_clr = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_data = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Plain frame, no decimation.
        run_frame(1'b1);
        chk("cnt_after_a", 64'(frame_cnt), 64'(1));
        chk("scale_en_a", 64'(scale_en), 64'(1));
        chk("err_line_a", 64'(err_line_len), 64'(0));
        chk("err_frame_a", 64'(err_frame_len), 64'(0));

        // Skip one frame after each emitted one, back-to-back frames.
        cfg_skip = 4'd1;
        run_frame(1'b1);
        run_frame(1'b0);
        run_frame(1'b1);
        chk("cnt_after_skip", 64'(frame_cnt), 64'(3));
        cfg_skip = 4'd0;
        run_frame(1'b0);
        chk("cnt_after_skip2", 64'(frame_cnt), 64'(3));

        // Reset in the middle of line 2.
        for (int i = 0; i < 9; i++)
            beat(1'b1, i == 0, (i % 4) == 3, 1'b1, i % 4, i / 4, 1'b0);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;

        // Short line 0 raises the sticky line-length error.
        beat(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 1'b1, 2, 0, 1'b0);
        chk("err_line_set", 64'(err_line_len), 64'(1));
        for (int i = 0; i < 4; i++)
            beat(1'b1, 1'b0, i == 3, 1'b1, i, 1, 1'b0);
        chk("err_line_sticky", 64'(err_line_len), 64'(1));
        err_clr = 1'b1;
        beat(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        err_clr = 1'b0;
        chk("err_line_clr", 64'(err_line_len), 64'(0));

        // SOF at (1,2), with eol and err_clr on the same beat: restart, frame error stays set.
        beat(1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0);
        err_clr = 1'b1;
        beat(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        err_clr = 1'b0;
        chk("err_frame_set", 64'(err_frame_len), 64'(1));
        chk("err_line_sofeol", 64'(err_line_len), 64'(0));
        chk("cnt_abort", 64'(frame_cnt), 64'(0));
        for (int i = 1; i < 16; i++)
            beat(1'b1, 1'b0, (i % 4) == 3, 1'b1, i % 4, i / 4, i == 15);
        chk("cnt_restart", 64'(frame_cnt), 64'(1));
        chk("err_line_restart", 64'(err_line_len), 64'(0));
        chk("err_frame_sticky", 64'(err_frame_len), 64'(1));

        // Config change mid-frame with 3-cycle gaps.
        cfg_scale_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) cfg_scale_en = 1'b1;
            beat(1'b1, i == 0, (i % 4) == 3, 1'b1, i % 4, i / 4, i == 15);
            chk("scale_en_hold", 64'(scale_en), 64'(0));
            if (i < 15)
                for (int g = 0; g < 3; g++)
                    beat(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        end
        chk("cnt_gapped", 64'(frame_cnt), 64'(2));
        chk("err_line_gapped", 64'(err_line_len), 64'(0));
        beat(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("scale_en_new", 64'(scale_en), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
